// File: rtl/alu_share_ctrl.sv
// Two-requester controller time-sharing one 16-bit ALU with a registered valid/ready response.
// Define ALU_SHARE_FIXED_PRIO_EN to make requester 0 always win contention (no round-robin pointer).
module alu_share_ctrl #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_op1,
  input  logic [DATA_W-1:0] req0_op2,
  input  logic [2:0]        req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_op1,
  input  logic [DATA_W-1:0] req1_op2,
  input  logic [2:0]        req1_ctrl,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zf,
  output logic              rsp_err,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, HOLD = 2'd2} state_t;

  state_t            state, state_nxt;
  logic              grant_vld;
  logic              grant_id;
  logic              accept;
  logic [DATA_W-1:0] op1_p1;
  logic [DATA_W-1:0] op2_p1;
  logic [2:0]        ctrl_p1;
  logic              id_p1;
  logic [DATA_W-1:0] alu_result;
  logic              alu_err;

  // Returns {err, result}; illegal codes yield a zero result with err set.
  function automatic logic [DATA_W:0] alu_eval(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic [2:0]        ctrl);
    logic [DATA_W:0] r;
    r = '0;
    case (ctrl)
      3'b010:  r = {1'b0, a + b};
      3'b110:  r = {1'b0, a - b};
      3'b000:  r = {1'b0, a & b};
      3'b001:  r = {1'b0, a | b};
      3'b111:  r = {1'b0, {(DATA_W-1){1'b0}}, (a < b)};
      default: r = {1'b1, {DATA_W{1'b0}}};
    endcase
    return r;
  endfunction

`ifndef ALU_SHARE_FIXED_PRIO_EN
  logic prio;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= 1'b0;
    end else if (accept) begin
      prio <= ~grant_id;
    end
  end
`endif

  always_comb begin
    grant_vld = req0_valid | req1_valid;
`ifdef ALU_SHARE_FIXED_PRIO_EN
    grant_id  = ~req0_valid;
`else
    grant_id  = (req0_valid && req1_valid) ? prio : req1_valid;
`endif
    accept     = (state == IDLE) && grant_vld;
    req0_ready = accept && !grant_id;
    req1_ready = accept && grant_id;
    busy       = (state != IDLE);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = EXEC;
      EXEC:    state_nxt = HOLD;
      HOLD:    if (rsp_valid && rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    {alu_err, alu_result} = alu_eval(op1_p1, op2_p1, ctrl_p1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Stage p1: operands of the granted requester
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op1_p1  <= '0;
      op2_p1  <= '0;
      ctrl_p1 <= '0;
      id_p1   <= 1'b0;
    end else if (accept) begin
      op1_p1  <= grant_id ? req1_op1  : req0_op1;
      op2_p1  <= grant_id ? req1_op2  : req0_op2;
      ctrl_p1 <= grant_id ? req1_ctrl : req0_ctrl;
      id_p1   <= grant_id;
    end
  end

  // Stage p2: response registers, frozen until the consumer takes them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zf     <= 1'b0;
      rsp_err    <= 1'b0;
    end else if (state == EXEC) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= id_p1;
      rsp_result <= alu_result;
      rsp_zf     <= (alu_result == '0);
      rsp_err    <= alu_err;
    end else if (state == HOLD && rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule
